// File: rtl/prng_param_top.sv
// Byte-serial Galois LFSR random number generator: WIDTH-bit state, STEPS
// steps per word, byte-serial seed load (MSB byte first), LSB-first output stream.
module prng_param_top #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] POLY         = 32'hA3000000,
    parameter int               STEPS        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 32'h02468ACD
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load_seed,
    input  logic [7:0] data_in,
    input  logic       get_random,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic       busy
);

    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(BYTES);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] adv_d;
    logic [WIDTH-1:0] seed_d;

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] v;
        v = s;
        for (int i = 0; i < STEPS; i++) begin
            v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        end
        return v;
    endfunction

    // shreg_q doubles as the seed shift register while loading.
    assign adv_d  = advance(lfsr_q);
    assign seed_d = {shreg_q[WIDTH-9:0], data_in};

    // Handshake: get_random is a request sampled only in IDLE or on the final
    // OUT byte; load_seed outranks it. Output bytes are not back-pressured:
    // a byte is valid for exactly the one cycle out_valid is high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            lfsr_q      <= DEFAULT_SEED;
            shreg_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_seed) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else if (get_random) begin
                        state_q     <= OUT;
                        lfsr_q      <= adv_d;
                        shreg_q     <= adv_d;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    shreg_q <= seed_d;
                    if (cnt_q == LAST) begin
                        // An all-zero seed would lock the LFSR, so substitute the default.
                        lfsr_q  <= (seed_d == '0) ? DEFAULT_SEED : seed_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                OUT: begin
                    if (load_seed) begin
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (get_random) begin
                            lfsr_q  <= adv_d;
                            shreg_q <= adv_d;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end else begin
                        shreg_q <= shreg_q >> 8;
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = out_valid_q ? shreg_q[7:0] : 8'h00;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_prng_param_top.sv
// Directed bench for prng_param_top: 32-bit default build, a STEPS=1 build with
// hand-derived words, and a 64-bit/64-step build, all on a shared stimulus.
module tb_prng_param_top;

    localparam logic [31:0] P32 = 32'hA3000000;
    localparam logic [31:0] D32 = 32'h02468ACD;
    localparam logic [63:0] P64 = 64'hD800000000000000;
    localparam logic [63:0] D64 = 64'h02468ACE13579BDF;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load_seed;
    logic       get_random;
    logic [7:0] data_in;

    logic [7:0] d32, d1, d64;
    logic       v32, v1, v64;
    logic       b32, b1, b64;

    always #5 clk = ~clk;

    prng_param_top u_dut (
        .clk(clk), .rstn(rstn), .load_seed(load_seed), .data_in(data_in),
        .get_random(get_random), .data_out(d32), .out_valid(v32), .busy(b32)
    );

    prng_param_top #(.STEPS(1)) u_s1 (
        .clk(clk), .rstn(rstn), .load_seed(load_seed), .data_in(data_in),
        .get_random(get_random), .data_out(d1), .out_valid(v1), .busy(b1)
    );

    prng_param_top #(.WIDTH(64), .POLY(P64), .STEPS(64), .DEFAULT_SEED(D64)) u_w64 (
        .clk(clk), .rstn(rstn), .load_seed(load_seed), .data_in(data_in),
        .get_random(get_random), .data_out(d64), .out_valid(v64), .busy(b64)
    );

    int           checks = 0;
    int           errors = 0;
    bit           mode64 = 1'b0;
    logic [127:0] m_main;
    logic [127:0] m_s1;
    logic [31:0]  last_s1;

    function automatic logic [127:0] model_step(input logic [127:0] s,
                                                input logic [127:0] poly, input int n);
        logic [127:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            if (v[0]) v = (v >> 1) ^ poly;
            else      v = v >> 1;
        end
        return v;
    endfunction

    function automatic int nb();
        return mode64 ? 8 : 4;
    endfunction

    function automatic logic [127:0] def_main();
        return mode64 ? {64'd0, D64} : {96'd0, D32};
    endfunction

    function automatic logic [127:0] adv_main(input logic [127:0] s);
        return mode64 ? model_step(s, {64'd0, P64}, 64) : model_step(s, {96'd0, P32}, 32);
    endfunction

    function automatic logic [7:0] obs_d();
        return mode64 ? d64 : d32;
    endfunction

    function automatic logic obs_v();
        return mode64 ? v64 : v32;
    endfunction

    function automatic logic obs_b();
        return mode64 ? b64 : b32;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, ".valid"}, obs_v(), 0);
        chk({tag, ".data"},  obs_d(), 0);
        chk({tag, ".busy"},  obs_b(), 0);
        if (!mode64) begin
            chk({tag, ".s1valid"}, v1, 0);
            chk({tag, ".s1data"},  d1, 0);
        end
    endtask

    task automatic adv_models();
        m_main = adv_main(m_main);
        m_s1   = model_step(m_s1, {96'd0, P32}, 1);
    endtask

    task automatic out_byte_chk(input string tag, input int b);
        chk({tag, ".valid"}, obs_v(), 1);
        chk({tag, ".busy"},  obs_b(), 1);
        chk({tag, ".byte"},  obs_d(), m_main[8*b +: 8]);
        if (!mode64) begin
            chk({tag, ".s1byte"}, d1, m_s1[8*b +: 8]);
            last_s1[8*b +: 8] = d1;
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        rstn       = 1'b0;
        load_seed  = 1'b0;
        get_random = 1'b0;
        data_in    = 8'h00;
        repeat (n) tick();
        idle_chk(tag);
        rstn   = 1'b1;
        m_main = def_main();
        m_s1   = {96'd0, D32};
    endtask

    task automatic get_word(input string tag);
        get_random = 1'b1;
        tick();
        get_random = 1'b0;
        adv_models();
        for (int b = 0; b < nb(); b++) begin
            out_byte_chk(tag, b);
            tick();
        end
        idle_chk({tag, ".end"});
    endtask

    // get_random is held high through the load to show it is ignored there.
    task automatic load(input string tag, input logic [127:0] seed, input bit with_get);
        logic [127:0] s;
        load_seed  = 1'b1;
        get_random = with_get;
        tick();
        load_seed  = 1'b0;
        get_random = 1'b1;
        chk({tag, ".lvalid"}, obs_v(), 0);
        chk({tag, ".lbusy"},  obs_b(), 1);
        for (int i = 0; i < nb(); i++) begin
            data_in = seed[8*(nb()-1-i) +: 8];
            tick();
            if (i < nb() - 1) begin
                chk({tag, ".lbusy"},  obs_b(), 1);
                chk({tag, ".lvalid"}, obs_v(), 0);
            end
        end
        get_random = 1'b0;
        data_in    = 8'h00;
        idle_chk({tag, ".ldone"});
        s      = mode64 ? {64'd0, seed[63:0]} : {96'd0, seed[31:0]};
        m_main = (s == 0) ? def_main() : s;
        m_s1   = (seed[31:0] == 0) ? {96'd0, D32} : {96'd0, seed[31:0]};
    endtask

    task automatic stream(input string tag, input int nwords);
        int total;
        total      = nwords * nb();
        get_random = 1'b1;
        tick();
        for (int c = 0; c < total; c++) begin
            if (c % nb() == 0) adv_models();
            out_byte_chk(tag, c % nb());
            get_random = (c != total - 1);
            tick();
        end
        idle_chk({tag, ".end"});
    endtask

    task automatic abort_at_byte2(input string tag, input logic [127:0] seed);
        get_random = 1'b1;
        tick();
        get_random = 1'b0;
        adv_models();
        for (int b = 0; b < 3; b++) begin
            out_byte_chk(tag, b);
            if (b < 2) tick();
        end
        load({tag, ".reload"}, seed, 1'b0);
    endtask

    task automatic reset_mid_stream(input string tag);
        get_random = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c % nb() == 0) adv_models();
            out_byte_chk(tag, c % nb());
            if (c == 5) rstn = 1'b0;
            tick();
        end
        get_random = 1'b0;
        idle_chk({tag, ".rst"});
        rstn   = 1'b1;
        m_main = def_main();
        m_s1   = {96'd0, D32};
    endtask

    task automatic reset_mid_load(input string tag);
        load_seed = 1'b1;
        tick();
        load_seed = 1'b0;
        data_in   = 8'h5A;
        tick();
        tick();
        rstn = 1'b0;
        tick();
        idle_chk({tag, ".rst"});
        rstn    = 1'b1;
        data_in = 8'h00;
        m_main  = def_main();
        m_s1    = {96'd0, D32};
    endtask

    initial begin
        rstn       = 1'b0;
        load_seed  = 1'b0;
        get_random = 1'b0;
        data_in    = 8'h00;
        last_s1    = '0;
        m_main     = '0;
        m_s1       = '0;

        // 32-bit builds
        mode64 = 1'b0;
        do_reset("reset", 3);
        get_word("w0");
        chk("hand_w0", last_s1, 32'hA2234566);
        get_word("w1");
        chk("hand_w1", last_s1, 32'h5111A2B3);
        get_word("w2");
        chk("hand_w2", last_s1, 32'h8B88D159);
        for (int i = 3; i < 200; i++) get_word("golden");

        load("seed", 128'h830ADB1C, 1'b0);
        get_word("seed_w0");
        chk("hand_seed_w0", last_s1, 32'h41856D8E);
        repeat (4) get_word("seed_w");

        load("zero", 128'h0, 1'b0);
        get_word("zero_w0");
        chk("hand_zero_w0", last_s1, 32'hA2234566);
        repeat (2) get_word("zero_w");

        stream("stream", 10);

        load("collide", 128'h12345678, 1'b1);
        repeat (2) get_word("collide_w");

        abort_at_byte2("abort", 128'h830ADB1C);
        get_word("abort_w0");
        chk("hand_abort_w0", last_s1, 32'h41856D8E);

        reset_mid_stream("midrst");
        get_word("midrst_w0");
        chk("hand_midrst_w0", last_s1, 32'hA2234566);
        get_word("midrst_w1");

        reset_mid_load("midload");
        get_word("midload_w0");
        chk("hand_midload_w0", last_s1, 32'hA2234566);

        // 64-bit / 64-step build
        mode64 = 1'b1;
        do_reset("reset64", 3);
        repeat (5) get_word("w64");
        load("seed64", 128'hFEDCBA9876543210, 1'b0);
        repeat (3) get_word("seed64_w");
        load("zero64", 128'h0, 1'b0);
        repeat (2) get_word("zero64_w");
        stream("stream64", 3);
        abort_at_byte2("abort64", 128'h0F1E2D3C4B5A6978);
        get_word("abort64_w");
        reset_mid_stream("midrst64");
        repeat (2) get_word("midrst64_w");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
